// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART receiver: FSM states, parity modes
// and the majority-vote helper used at every bit sample point.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned MIN_DIV  = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_3ff.sv
// Three-flop synchronizer for the asynchronous serial line; resets to idle-high.
module sync_3ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[1:0], d_i};
    end

    assign q_o = sync_q[2];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled by a per-frame latched divisor, 2-of-3
// majority sampling at mid-bit, optional parity and one or two stop bits.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PARITY = 0,
    parameter int unsigned STOP_W = 1,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned BIT_W = $clog2(DATA_W);

    logic rx_s;
    logic rx_p1_q, rx_p2_q;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               stop_q, stop_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               perr_acc_q, perr_acc_d;
    logic               ferr_acc_q, ferr_acc_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               vld_q, vld_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;

    logic             sample;
    logic             at_mid, at_end, last_stop;
    logic [DIV_W-1:0] div_clamped;

    sync_3ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (din),
        .q_o   (rx_s)
    );

    assign sample      = maj3(rx_p2_q, rx_p1_q, rx_s);
    assign at_mid      = (cnt_q == ((div_q >> 1) - DIV_W'(1)));
    assign at_end      = (cnt_q == (div_q - DIV_W'(1)));
    assign last_stop   = (STOP_W == 1) || stop_q;
    assign div_clamped = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p1_q    <= 1'b1;
            rx_p2_q    <= 1'b1;
            state_q    <= ST_IDLE;
            div_q      <= DIV_W'(MIN_DIV);
            cnt_q      <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            dout_q     <= '0;
            vld_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_p1_q    <= rx_s;
            rx_p2_q    <= rx_p1_q;
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            dout_q     <= dout_d;
            vld_q      <= vld_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        dout_d     = dout_q;
        vld_d      = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = at_end ? '0 : cnt_q + DIV_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // Edge-only entry: a line held low after a break cannot restart a frame.
                if (rx_p1_q && !rx_s) begin
                    state_d    = ST_START;
                    div_d      = div_clamped;
                    cnt_d      = '0;
                    bit_d      = '0;
                    stop_d     = 1'b0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                end
            end
            ST_START: begin
                if (at_mid && sample) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (at_mid) begin
                    shift_d = {sample, shift_q[DATA_W-1:1]};
                end
                if (at_end) begin
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (at_mid) begin
                    perr_acc_d = (sample != ((^shift_q) ^ (PARITY == PAR_ODD)));
                end
                if (at_end) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (at_mid) begin
                    if (!sample) ferr_acc_d = 1'b1;
                    if (last_stop) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        dout_d  = shift_q;
                        vld_d   = 1'b1;
                        perr_d  = perr_acc_q;
                        ferr_d  = ferr_acc_q | !sample;
                    end
                end else if (at_end) begin
                    stop_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dout       = dout_q;
    assign dout_vld   = vld_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three parity/stop configurations driven with
// directed and random frames, checked against a frame-level line model.
module tb_uart_rx_cfg;

    localparam int unsigned NI = 3;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bdiv [NI];
    logic        din  [NI];
    logic [7:0]  dout [NI];
    logic        vld  [NI];
    logic        perr [NI];
    logic        ferr [NI];
    logic        busy [NI];

    int unsigned par_mode [NI] = '{0, 2, 1};
    int unsigned stop_n   [NI] = '{1, 1, 2};

    exp_t q0[$], q1[$], q2[$];
    logic [7:0] last_dout [NI] = '{default: 8'h00};
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.DATA_W(8), .PARITY(0), .STOP_W(1), .DIV_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .baud_div(bdiv[0]), .din(din[0]), .dout(dout[0]),
        .dout_vld(vld[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .busy(busy[0]));
    uart_rx_cfg #(.DATA_W(8), .PARITY(2), .STOP_W(1), .DIV_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .baud_div(bdiv[1]), .din(din[1]), .dout(dout[1]),
        .dout_vld(vld[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .busy(busy[1]));
    uart_rx_cfg #(.DATA_W(8), .PARITY(1), .STOP_W(2), .DIV_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .baud_div(bdiv[2]), .din(din[2]), .dout(dout[2]),
        .dout_vld(vld[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .busy(busy[2]));

    function automatic void push(int i, exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: every output pulse is matched against the next expected frame.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (vld[i] === 1'b1) begin
                checks++;
                if (qsize(i) == 0) begin
                    failures++;
                    $display("FAIL unexpected_vld inst=%0d got dout=%h perr=%b ferr=%b, required no pulse",
                             i, dout[i], perr[i], ferr[i]);
                end else begin
                    exp_t e;
                    e = pop(i);
                    if (dout[i] !== e.data || perr[i] !== e.perr || ferr[i] !== e.ferr) begin
                        failures++;
                        $display("FAIL frame inst=%0d got dout=%h perr=%b ferr=%b, required dout=%h perr=%b ferr=%b",
                                 i, dout[i], perr[i], ferr[i], e.data, e.perr, e.ferr);
                    end
                    last_dout[i] = e.data;
                end
            end else begin
                if (perr[i] !== 1'b0 || ferr[i] !== 1'b0) begin
                    checks++;
                    failures++;
                    $display("FAIL stray_err inst=%0d got perr=%b ferr=%b, required 0 0", i, perr[i], ferr[i]);
                end
                if (dout[i] !== last_dout[i]) begin
                    checks++;
                    failures++;
                    $display("FAIL dout_hold inst=%0d got %h, required %h", i, dout[i], last_dout[i]);
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line model: start, 8 data bits LSB first, optional parity, stop bits,
    // each held for max(div,4) cycles.
    task automatic send(int i, logic [7:0] d, logic [15:0] div, logic par_flip,
                        logic [1:0] sb, int idle_after);
        int   p;
        int   ones;
        logic good_par;
        exp_t e;
        p        = (div < 16'd4) ? 4 : int'(div);
        ones     = $countones(d);
        good_par = (par_mode[i] == 2) ? logic'(ones % 2) : logic'(1 - (ones % 2));
        e.data   = d;
        e.perr   = (par_mode[i] != 0) && par_flip;
        e.ferr   = (stop_n[i] == 1) ? !sb[0] : !(sb[0] && sb[1]);
        push(i, e);
        bdiv[i] = div;
        din[i]  = 1'b0;
        tick(p);
        for (int b = 0; b < 8; b++) begin
            din[i] = d[b];
            tick(p);
            if (b == 3) bdiv[i] = 16'($urandom);
        end
        if (par_mode[i] != 0) begin
            din[i] = good_par ^ par_flip;
            tick(p);
        end
        for (int s = 0; s < int'(stop_n[i]); s++) begin
            din[i] = sb[s];
            tick(p);
        end
        din[i] = 1'b1;
        tick(idle_after * p);
    endtask

    task automatic check_bit(string name, logic got, logic req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got %b, required %b", name, got, req);
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < NI; i++) begin
            din[i]  = 1'b1;
            bdiv[i] = 16'd16;
        end
        #2;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (dout[i] !== 8'h00 || vld[i] !== 1'b0 || perr[i] !== 1'b0 ||
                ferr[i] !== 1'b0 || busy[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state inst=%0d got dout=%h vld=%b perr=%b ferr=%b busy=%b, required all 0",
                         i, dout[i], vld[i], perr[i], ferr[i], busy[i]);
            end
        end
        tick(4);
        rst_n = 1'b1;
        tick(4);

        send(0, 8'hA5, 16'd16, 1'b0, 2'b11, 2);

        // Three-cycle low glitch must be rejected as a false start.
        bdiv[0] = 16'd16;
        din[0]  = 1'b0;
        tick(3);
        din[0]  = 1'b1;
        k = 0;
        while (busy[0] !== 1'b1 && k < 10) begin
            tick(1);
            k++;
        end
        check_bit("glitch_busy_rise", busy[0], 1'b1);
        k = 0;
        while (busy[0] !== 1'b0 && k < 12) begin
            tick(1);
            k++;
        end
        check_bit("glitch_busy_fall", busy[0], 1'b0);
        tick(20);

        send(1, 8'h3C, 16'd16, 1'b1, 2'b11, 2);
        send(0, 8'h81, 16'd16, 1'b0, 2'b10, 2);

        // Break: 30 bit times low, then line released.
        push(0, '{data: 8'h00, perr: 1'b0, ferr: 1'b1});
        bdiv[0] = 16'd16;
        din[0]  = 1'b0;
        tick(30 * 16);
        din[0]  = 1'b1;
        tick(3 * 16);
        send(0, 8'h5A, 16'd16, 1'b0, 2'b11, 1);

        send(2, 8'h55, 16'd16, 1'b0, 2'b11, 0);
        send(2, 8'hAA, 16'd16, 1'b0, 2'b11, 2);

        // Reset in the middle of the data bits, then a clean frame.
        bdiv[0] = 16'd16;
        din[0]  = 1'b0;
        tick(16);
        din[0]  = 1'b1;
        tick(40);
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) last_dout[i] = 8'h00;
        tick(1);
        check_bit("reset_busy", busy[0], 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        send(0, 8'h0F, 16'd16, 1'b0, 2'b11, 2);

        for (int f = 0; f < 24; f++) begin
            int         i;
            logic [1:0] sb;
            logic       bad;
            i   = int'($urandom_range(0, 2));
            sb  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            bad = (stop_n[i] == 1) ? !sb[0] : !(sb[0] && sb[1]);
            send(i, 8'($urandom), 16'($urandom_range(1, 20)), ($urandom_range(0, 3) == 0), sb,
                 bad ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2)));
        end

        tick(60);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (qsize(i) != 0) begin
                failures++;
                $display("FAIL missing_frames inst=%0d got %0d pending, required 0", i, qsize(i));
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
